ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 154 +++++++++++++++
 tb/tb_ps2_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) from the
// raw PS/2 pins and presents each valid byte with a one-cycle strobe. Scan codes
// are passed through unmodified; break/extended decoding happens downstream.
//
// Ports:
//   Clock     system clock, rising edge
//   Reset     asynchronous, active-high reset
//   Enable    receiver enable; low holds the deframer in IDLE
//   PS2_CLK   raw PS/2 clock pin (asynchronous)
//   PS2_DAT   raw PS/2 data pin (asynchronous)
//   data      last valid received byte (held between frames)
//   data_en   one-cycle strobe: data is new this cycle
//   frame_err one-cycle strobe: parity, stop or timeout error
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Input conditioning: synchronisers and glitch filter idle high.
    logic [1:0] clk_sync, dat_sync;
    logic       clk_filt;
    logic [7:0] filt_cnt;
    logic       differ, flip, fall, samp;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign differ = clk_sync[1] != clk_filt;
    // The filtered clock flips on the FILTER_LEN-th consecutive differing cycle.
    assign flip   = differ && (filt_cnt == 8'(FILTER_LEN - 1));
    // Fall pulse is taken from the flip condition itself, so the FSM acts in the
    // same cycle the filtered clock goes low (saves one cycle of latency).
    assign fall   = flip && !clk_sync[1];
    assign samp   = dat_sync[1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (!differ) begin
            filt_cnt <= '0;
        end else if (flip) begin
            filt_cnt <= '0;
            clk_filt <= clk_sync[1];
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // Deframer
    state_t         state, state_n;
    logic [2:0]     bitcnt, bitcnt_n;
    logic [7:0]     shreg, shreg_n;
    logic           par, par_n;
    logic [TW-1:0]  to_cnt, to_cnt_n;
    logic           load, err;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            data      <= '0;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            par       <= par_n;
            to_cnt    <= to_cnt_n;
            data_en   <= load;
            frame_err <= err;
            if (load) data <= shreg;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        to_cnt_n = to_cnt;
        load     = 1'b0;
        err      = 1'b0;
        if (!Enable) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            to_cnt_n = '0;
        end else begin
            // Inactivity timeout; a fall pulse in the expiry cycle keeps the frame alive.
            if (state == IDLE || fall) begin
                to_cnt_n = '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_n = '0;
                state_n  = IDLE;
                err      = 1'b1;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        // A high sample here is a spurious start: ignored silently.
                        if (!samp) begin
                            state_n  = DATA;
                            bitcnt_n = '0;
                        end
                    end
                    DATA: begin
                        shreg_n  = {samp, shreg[7:1]};
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state_n = PARITY;
                    end
                    PARITY: begin
                        par_n   = samp;
                        state_n = STOP;
                    end
                    STOP: begin
                        state_n = IDLE;
                        if (samp && ((^shreg) ^ par)) load = 1'b1;
                        else                          err  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

    localparam int HALF = 60;
    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int LAT  = FL + 4;

    logic       Clock = 1'b0;
    logic       Reset, Enable, PS2_CLK, PS2_DAT;
    logic [7:0] data;
    logic       data_en, frame_err;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_fall = 0;

    // Expected strobe: kind, byte, and the cycle window it must land in.
    typedef struct {
        bit          err;
        logic [7:0]  val;
        int unsigned lo;
        int unsigned hi;
    } ev_t;

    ev_t        q[$];
    logic [7:0] exp_data = 8'h00;
    bit         prev_en  = 1'b0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data      (data),
        .data_en   (data_en),
        .frame_err (frame_err)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge Clock) begin
        ev_t e;
        if (Reset) begin
            exp_data = 8'h00;
            prev_en  = 1'b0;
        end else begin
            if (data_en || frame_err) begin
                chk("both_strobes", {31'd0, data_en & frame_err}, 0);
                if (data_en) chk("en_len", {31'd0, prev_en}, 0);
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, data_en, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    chk("kind", {31'd0, frame_err}, {31'd0, e.err});
                    chk("early", {31'd0, cyc >= e.lo}, 1);
                    chk("late", {31'd0, cyc <= e.hi}, 1);
                    if (!e.err) begin
                        chk("data", {24'd0, data}, {24'd0, e.val});
                        exp_data = e.val;
                    end else begin
                        chk("hold", {24'd0, data}, {24'd0, exp_data});
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].hi) begin
                chk("missing_strobe", {30'd0, data_en, frame_err}, q[0].err ? 2'b01 : 2'b10);
                void'(q.pop_front());
            end
            prev_en = data_en;
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Send the first nbits of frame {stop, parity, byte, start}; optionally
    // inject 3-cycle glitches in both clock phases; optionally expect a strobe.
    task automatic send(input logic [7:0] b, input logic p, input logic s,
                        input int nbits, input bit glitch, input bit expect_ev);
        logic [10:0] fr;
        ev_t         e;
        fr = {s, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = fr[i];
            if (glitch) begin
                wcyc(20); PS2_CLK = 1'b0; wcyc(3); PS2_CLK = 1'b1; wcyc(HALF - 23);
            end else wcyc(HALF);
            PS2_CLK   = 1'b0;
            last_fall = cyc;
            if (i == 10 && expect_ev) begin
                e.err = !(s == 1'b1 && ($countones({b, p}) % 2 == 1));
                e.val = b;
                e.lo  = cyc;
                e.hi  = cyc + LAT;
                q.push_back(e);
            end
            if (glitch) begin
                wcyc(20); PS2_CLK = 1'b1; wcyc(3); PS2_CLK = 1'b0; wcyc(HALF - 23);
            end else wcyc(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        wcyc(4 * HALF);
    endtask

    initial begin
        ev_t        e;
        logic [7:0] b;
        logic       p, s;
        Reset   = 1'b1;
        Enable  = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wcyc(3);
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_en", {31'd0, data_en}, 0);
        chk("rst_err", {31'd0, frame_err}, 0);
        Reset = 1'b0;
        wcyc(20);

        send(8'h16, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b1);
        send(8'h16, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        // Bad parity, then bad stop: error strobe, data stays 0x16.
        send(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send(8'h5A, 1'b1, 1'b0, 11, 1'b0, 1'b1);
        chk("hold_16", {24'd0, data}, 32'h16);
        // Glitched clock must still yield exactly one 0x45.
        send(8'h45, 1'b0, 1'b1, 11, 1'b1, 1'b1);

        // Start + 4 data bits, then idle: timeout error expected.
        send(8'hA5, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        e.err = 1'b1; e.val = 8'h00;
        e.lo  = last_fall + TO;
        e.hi  = last_fall + TO + LAT + 4;
        q.push_back(e);
        wcyc(2500 - 4 * HALF);
        chk("timeout_seen", q.size(), 0);
        send(8'h5A, 1'b1, 1'b1, 11, 1'b0, 1'b1);

        // Reset mid-frame, then a frame while disabled: no strobes at all.
        send(8'h1E, 1'b1, 1'b1, 6, 1'b0, 1'b0);
        Reset = 1'b1;
        wcyc(5);
        chk("midrst_data", {24'd0, data}, 0);
        chk("midrst_en", {31'd0, data_en}, 0);
        Reset = 1'b0;
        wcyc(10);
        Enable = 1'b0;
        send(8'h26, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        chk("dis_data", {24'd0, data}, 0);
        Enable = 1'b1;
        wcyc(10);
        send(8'h3D, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        chk("after_en", {24'd0, data}, 32'h3D);

        // Random frames, some with corrupted parity or stop bit.
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            send(b, p, s, 11, 1'($urandom_range(0, 1)), 1'b1);
        end

        wcyc(50);
        chk("pending", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
